// File: rtl/pe_col_acc.sv
// pe_col_acc: column-drain accumulator of TILES Q2.13 partial sums with saturating result FIFO (optional PE_COL_ACC_SAT_CNT_EN clip counter)
module pe_col_acc #(
    parameter int TILES = 4,
    parameter int DEPTH = 8
) (
    input  logic        I_CLK,
    input  logic        I_RST,
    input  logic        I_PSUM_VLD,
    input  logic [15:0] I_PSUM,
    output logic        O_PSUM_RDY,
    input  logic        I_CLR,
    output logic        O_VLD,
    output logic [15:0] O_DATA,
    input  logic        I_RDY,
`ifdef PE_COL_ACC_SAT_CNT_EN
    output logic [7:0]  O_SAT_CNT,
`endif
    output logic [3:0]  O_TILE_CNT
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    logic [19:0] acc_q, acc_d, sum;
    logic [3:0] cnt_q, cnt_d;
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [AW:0] count_q, count_d;
    logic [15:0] hold_q, hold_d, sat;
    logic [15:0] mem [DEPTH];
    logic accept, last, push, pop, pos_clip, neg_clip;
    assign O_PSUM_RDY = ~I_RST & (count_q != FULL);
    assign O_VLD = count_q != '0;
    assign O_DATA = O_VLD ? mem[rp_q] : hold_q;
    assign O_TILE_CNT = cnt_q;
    // Next-state for the accumulator and FIFO bookkeeping; clear overrides any accept
    always_comb begin
        accept = I_PSUM_VLD & O_PSUM_RDY;
        sum = acc_q + {{4{I_PSUM[15]}}, I_PSUM};
        last = cnt_q == 4'(TILES - 1);
        pos_clip = ~sum[19] & |sum[18:15];
        neg_clip = sum[19] & ~&sum[18:15];
        sat = pos_clip ? 16'h7FFF : neg_clip ? 16'h8000 : sum[15:0];
        push = accept & last & ~I_CLR;
        pop = O_VLD & I_RDY;
        acc_d = (I_CLR | (accept & last)) ? '0 : accept ? sum : acc_q;
        cnt_d = (I_CLR | (accept & last)) ? '0 : accept ? cnt_q + 4'd1 : cnt_q;
        wp_d = push ? wp_q + 1'b1 : wp_q;
        rp_d = pop ? rp_q + 1'b1 : rp_q;
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
        hold_d = pop ? mem[rp_q] : hold_q;
    end
    // State registers with asynchronous reset discarding accumulation and FIFO contents
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            acc_q <= '0;
            cnt_q <= '0;
            wp_q <= '0;
            rp_q <= '0;
            count_q <= '0;
            hold_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            wp_q <= wp_d;
            rp_q <= rp_d;
            count_q <= count_d;
            hold_q <= hold_d;
        end
    end
    // FIFO storage write on each completed result
    always_ff @(posedge I_CLK) begin
        if (push) mem[wp_q] <= sat;
    end
`ifdef PE_COL_ACC_SAT_CNT_EN
    logic [7:0] sat_cnt_q;
    assign O_SAT_CNT = sat_cnt_q;
    // Count clipped results, sticking at 255; only reset clears it
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) sat_cnt_q <= '0;
        else if (push & (pos_clip | neg_clip) & (sat_cnt_q != 8'hFF)) sat_cnt_q <= sat_cnt_q + 8'd1;
    end
`endif
endmodule

// File: tb/tb_pe_col_acc.sv
// tb_pe_col_acc: directed self-checking bench for pe_col_acc (TILES=4, DEPTH=8)
module tb_pe_col_acc;
    logic clk = 1'b0, rst = 1'b1, vld = 1'b0, clr = 1'b0, rdy_in = 1'b0;
    logic [15:0] psum = '0;
    logic psum_rdy, o_vld;
    logic [15:0] o_data;
    logic [3:0] tile_cnt;
`ifdef PE_COL_ACC_SAT_CNT_EN
    logic [7:0] sat_cnt;
`endif
    int checks = 0, failures = 0;

    pe_col_acc #(.TILES(4), .DEPTH(8)) dut (
        .I_CLK(clk), .I_RST(rst), .I_PSUM_VLD(vld), .I_PSUM(psum), .O_PSUM_RDY(psum_rdy),
        .I_CLR(clr), .O_VLD(o_vld), .O_DATA(o_data), .I_RDY(rdy_in),
`ifdef PE_COL_ACC_SAT_CNT_EN
        .O_SAT_CNT(sat_cnt),
`endif
        .O_TILE_CNT(tile_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] v);
        int n = 0;
        psum = v;
        vld = 1'b1;
        while (!psum_rdy && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            checks++; failures++;
            $display("FAIL send_timeout psum_rdy=%0b required=1", psum_rdy);
        end
        tick();
        vld = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks += 5;
        if (o_vld !== 1'b0) begin failures++; $display("FAIL rst_vld got=%0b exp=0", o_vld); end
        if (o_data !== 16'h0) begin failures++; $display("FAIL rst_data got=%h exp=0000", o_data); end
        if (tile_cnt !== 4'd0) begin failures++; $display("FAIL rst_tile got=%0d exp=0", tile_cnt); end
        if (psum_rdy !== 1'b0) begin failures++; $display("FAIL rst_psum_rdy got=%0b exp=0", psum_rdy); end
        tick();
        rst = 1'b0;
        tick();
        if (psum_rdy !== 1'b1) begin failures++; $display("FAIL post_rst_rdy got=%0b exp=1", psum_rdy); end
    endtask

    task automatic test_basic();
        logic [15:0] vals [4] = '{16'h2000, 16'h1000, 16'hF000, 16'h0800};
        logic [3:0] exp_cnt [4] = '{4'd1, 4'd2, 4'd3, 4'd0};
        rdy_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(vals[i]);
            checks += 2;
            if (tile_cnt !== exp_cnt[i]) begin failures++; $display("FAIL basic_tile%0d got=%0d exp=%0d", i, tile_cnt, exp_cnt[i]); end
            if (o_vld !== (i == 3)) begin failures++; $display("FAIL basic_vld%0d got=%0b exp=%0b", i, o_vld, i == 3); end
        end
        checks++;
        if (o_data !== 16'h2800) begin failures++; $display("FAIL basic_data got=%h exp=2800", o_data); end
        tick();
        checks++;
        if (o_vld !== 1'b0) begin failures++; $display("FAIL basic_pulse got=%0b exp=0", o_vld); end
        rdy_in = 1'b0;
    endtask

    task automatic test_saturation();
        logic [15:0] ins [2] = '{16'h6000, 16'hA000};
        logic [15:0] exps [2] = '{16'h7FFF, 16'h8000};
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 4; i++) send(ins[g]);
            checks++;
            if (o_vld !== 1'b1 || o_data !== exps[g]) begin
                failures++; $display("FAIL sat%0d vld=%0b data=%h exp=%h", g, o_vld, o_data, exps[g]);
            end
            rdy_in = 1'b1;
            tick();
            rdy_in = 1'b0;
        end
`ifdef PE_COL_ACC_SAT_CNT_EN
        checks++;
        if (sat_cnt !== 8'd2) begin failures++; $display("FAIL sat_cnt got=%0d exp=2", sat_cnt); end
`endif
    endtask

    task automatic test_backpressure();
        rdy_in = 1'b0;
        for (int k = 1; k <= 8; k++)
            for (int i = 0; i < 4; i++) send(16'(k * 16));
        checks += 2;
        if (psum_rdy !== 1'b0) begin failures++; $display("FAIL bp_full_rdy got=%0b exp=0", psum_rdy); end
        if (o_vld !== 1'b1 || o_data !== 16'h0040) begin failures++; $display("FAIL bp_head vld=%0b data=%h exp=0040", o_vld, o_data); end
        psum = 16'h0100;
        vld = 1'b1;
        repeat (3) tick();
        checks++;
        if (tile_cnt !== 4'd0) begin failures++; $display("FAIL bp_held tile=%0d exp=0", tile_cnt); end
        rdy_in = 1'b1;
        tick();
        rdy_in = 1'b0;
        tick();
        vld = 1'b0;
        checks++;
        if (tile_cnt !== 4'd1) begin failures++; $display("FAIL bp_33rd tile=%0d exp=1", tile_cnt); end
        rdy_in = 1'b1;
        for (int k = 2; k <= 8; k++) begin
            checks++;
            if (o_vld !== 1'b1 || o_data !== 16'(k * 64)) begin
                failures++; $display("FAIL bp_drain%0d vld=%0b data=%h exp=%h", k, o_vld, o_data, 16'(k * 64));
            end
            tick();
        end
        checks++;
        if (o_vld !== 1'b0) begin failures++; $display("FAIL bp_empty vld=%0b exp=0", o_vld); end
        rdy_in = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_clear();
        rdy_in = 1'b0;
        send(16'h2000);
        send(16'h2000);
        clr = 1'b1;
        send(16'h2000);
        clr = 1'b0;
        checks += 2;
        if (tile_cnt !== 4'd0) begin failures++; $display("FAIL clr_tile got=%0d exp=0", tile_cnt); end
        if (o_vld !== 1'b0) begin failures++; $display("FAIL clr_vld got=%0b exp=0", o_vld); end
        for (int i = 0; i < 4; i++) send(16'h0800);
        checks++;
        if (o_vld !== 1'b1 || o_data !== 16'h2000) begin failures++; $display("FAIL clr_result vld=%0b data=%h exp=2000", o_vld, o_data); end
        rdy_in = 1'b1;
        tick();
        rdy_in = 1'b0;
    endtask

    task automatic test_async_reset();
        rdy_in = 1'b0;
        for (int i = 0; i < 14; i++) send(16'h0040);
        checks += 2;
        if (o_vld !== 1'b1) begin failures++; $display("FAIL ar_pre_vld got=%0b exp=1", o_vld); end
        if (tile_cnt !== 4'd2) begin failures++; $display("FAIL ar_pre_tile got=%0d exp=2", tile_cnt); end
        #2 rst = 1'b1;
        #1;
        checks += 3;
        if (o_vld !== 1'b0) begin failures++; $display("FAIL ar_vld got=%0b exp=0", o_vld); end
        if (tile_cnt !== 4'd0) begin failures++; $display("FAIL ar_tile got=%0d exp=0", tile_cnt); end
        if (psum_rdy !== 1'b0) begin failures++; $display("FAIL ar_rdy got=%0b exp=0", psum_rdy); end
        #1 rst = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) send(16'h0040);
        checks++;
        if (o_vld !== 1'b1 || o_data !== 16'h0100) begin failures++; $display("FAIL ar_result vld=%0b data=%h exp=0100", o_vld, o_data); end
        rdy_in = 1'b1;
        tick();
        rdy_in = 1'b0;
        checks++;
        if (o_vld !== 1'b0) begin failures++; $display("FAIL ar_single vld=%0b exp=0", o_vld); end
    endtask

    task automatic test_push_pop();
        rdy_in = 1'b0;
        for (int i = 0; i < 4; i++) send(16'h0010);
        for (int i = 0; i < 3; i++) send(16'h0020);
        rdy_in = 1'b1;
        send(16'h0020);
        rdy_in = 1'b0;
        checks++;
        if (o_vld !== 1'b1 || o_data !== 16'h0080) begin failures++; $display("FAIL pp_head vld=%0b data=%h exp=0080", o_vld, o_data); end
        rdy_in = 1'b1;
        tick();
        rdy_in = 1'b0;
        checks++;
        if (o_vld !== 1'b0) begin failures++; $display("FAIL pp_count vld=%0b exp=0", o_vld); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_clear();
        test_async_reset();
        test_push_pop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
